stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: data width per channel and on the output.
REQ-002 The block SHALL have parameter NUM_CH, default 4: number of requester channels, range 2..16.
REQ-003 The block SHALL have parameter BURST_LEN, default 4: maximum transfers per grant, range 1..256.
REQ-004 The block SHALL derive localparam LB_NUM_CH = $clog2(NUM_CH).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous flush, same effect as rst.
REQ-008 The block SHALL have port in_data, input, NUM_CH*DATA_WIDTH bits: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port in_valid, input, NUM_CH bits: per-channel valid.
REQ-010 The block SHALL have port in_ready, output, NUM_CH bits: per-channel ready.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH bits: data of the granted channel.
REQ-012 The block SHALL have port out_ch, output, LB_NUM_CH bits: index of the granted channel.
REQ-013 The block SHALL have port out_valid, output, 1 bit: output valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream ready, typically sync FIFO in_ready.
REQ-015 The block SHALL have port busy, output, 1 bit: high while in GRANT.

Function
REQ-016 The block SHALL define a transfer on channel i as in_valid[i] & in_ready[i]; an output transfer SHALL be out_valid & out_ready, and the two SHALL always coincide.
REQ-017 The block SHALL implement FSM states IDLE and GRANT, with registers grant_r (LB_NUM_CH bits), last_r (LB_NUM_CH bits) and beat_r (width $clog2(BURST_LEN+1)).
REQ-018 In IDLE, out_valid SHALL be 0, in_ready SHALL be all 0, and busy SHALL be 0.
REQ-019 In IDLE with any in_valid bit set, the block SHALL load grant_r with the first set channel searching (last_r+1) mod NUM_CH upward with wrap-around, clear beat_r, and enter GRANT the next cycle.
REQ-020 In IDLE with no in_valid bit set, the block SHALL stay in IDLE with all registers unchanged.
REQ-021 In GRANT, the block SHALL drive out_valid = in_valid[grant_r], out_data = channel grant_r data, and in_ready[grant_r] = out_ready, combinationally.
REQ-022 In GRANT, in_ready SHALL be 0 for every channel other than grant_r.
REQ-023 out_ch SHALL equal grant_r in all states; busy SHALL be 1 in GRANT.
REQ-024 In GRANT, each transfer SHALL increment beat_r.
REQ-025 On a transfer that makes beat_r reach BURST_LEN, the block SHALL go to IDLE and load last_r with grant_r.
REQ-026 In GRANT, a cycle with in_valid[grant_r] = 0 SHALL end the grant: go to IDLE and load last_r with grant_r.
REQ-027 In GRANT, a cycle with in_valid[grant_r] = 1 and out_ready = 0 SHALL hold all state; there is no timeout.
REQ-028 Latency: first transfer no earlier than 1 cycle after in_valid rises in IDLE; exactly one IDLE cycle between consecutive grants.
REQ-029 Fairness: with all channels continuously valid and out_ready = 1, grants SHALL rotate 0,1,..,NUM_CH-1,0 with BURST_LEN beats each.
REQ-030 Simultaneous requests in IDLE SHALL be resolved only by the rotating priority of REQ-019, never by fixed index.
REQ-031 With BURST_LEN = 1, every grant SHALL carry exactly one transfer.
REQ-032 The block SHALL NOT buffer data; its only state SHALL be the FSM, grant_r, last_r and beat_r.

Reset
REQ-033 On rst or clear, the block SHALL next cycle be in IDLE with grant_r = 0, last_r = NUM_CH-1 (so channel 0 has first priority) and beat_r = 0.
REQ-034 During and after reset, outputs SHALL be out_valid = 0, in_ready = 0, busy = 0 and out_ch = 0.
REQ-035 rst or clear asserted mid-GRANT SHALL abort the burst at once; no transfer SHALL occur in the reset cycle, since in_ready is forced to 0 while rst or clear is high.
REQ-036 rst and clear SHALL take priority over all FSM transitions.

Verification
REQ-037 The bench SHALL cover the single requester case: NUM_CH=4, BURST_LEN=4, ch2 sends 6 words, out_ready=1 -> words 0-3 with out_ch=2, one bubble, words 4-5; busy low in the bubble.
REQ-038 The bench SHALL cover the all-valid rotation case: all 4 channels always valid, out_ready=1 -> out_ch sequence 0x4,1x4,2x4,3x4,0x4, with one idle cycle between groups.
REQ-039 The bench SHALL cover backpressure: ch1 granted, out_ready low 5 cycles mid-burst -> out_data and out_ch stable, in_ready[1]=0, beat_r unchanged, burst completes after release.
REQ-040 The bench SHALL cover early drop: ch3 valid for 2 words then low -> grant ends after 2 transfers, last_r=3, and the next request from ch0 and ch3 together grants ch0.
REQ-041 The bench SHALL cover mid-burst reset: clear pulsed after beat 2 of a ch1 burst -> no transfer in the clear cycle, IDLE next, and a later simultaneous request from all channels grants ch0.
REQ-042 The bench SHALL carry a continuous scoreboard: per-channel order preserved, no data loss or duplication, and at most one in_ready bit high in any cycle.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter: grants one requester channel at a time for a
// burst of up to BURST_LEN transfers, then rotates priority past it.
// Combinational pass-through of the granted channel; no data buffering.
module stream_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned BURST_LEN  = 4,
  localparam int unsigned LB_NUM_CH = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [LB_NUM_CH-1:0]         out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state_r, state_nxt;
  logic [LB_NUM_CH-1:0]   grant_r, grant_nxt;
  logic [LB_NUM_CH-1:0]   last_r, last_nxt;
  logic [BEAT_W-1:0]      beat_r, beat_nxt;
  logic [LB_NUM_CH-1:0]   pick;
  logic [DATA_WIDTH-1:0]  ch_data [NUM_CH];
  logic                   flush;

  assign flush = rst | clear;

  // Split the flat input bus into per-channel words.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_data[c] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First valid channel starting at last_r+1, wrapping; scanning from the
  // farthest offset down leaves the nearest hit as the final assignment.
  always_comb begin
    pick = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (in_valid[LB_NUM_CH'((int'(last_r) + k) % NUM_CH)]) begin
        pick = LB_NUM_CH'((int'(last_r) + k) % NUM_CH);
      end
    end
  end

  // Output steering; flush forces every handshake low so no transfer can land.
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = ch_data[grant_r];
    out_ch    = grant_r;
    if (state_r == GRANT && !flush) begin
      out_valid         = in_valid[grant_r];
      in_ready[grant_r] = out_ready;
      busy              = 1'b1;
    end
  end

  // Next-state: arbitrate in IDLE, count beats and end bursts in GRANT.
  always_comb begin
    state_nxt = state_r;
    grant_nxt = grant_r;
    last_nxt  = last_r;
    beat_nxt  = beat_r;
    case (state_r)
      IDLE: begin
        if (|in_valid) begin
          grant_nxt = pick;
          beat_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!in_valid[grant_r]) begin
          state_nxt = IDLE;
          last_nxt  = grant_r;
        end else if (out_ready) begin
          beat_nxt = beat_r + BEAT_W'(1);
          if (beat_r == BEAT_W'(BURST_LEN - 1)) begin
            state_nxt = IDLE;
            last_nxt  = grant_r;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; rst/clear override every transition and give ch0 first priority.
  always_ff @(posedge clk) begin
    if (flush) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= LB_NUM_CH'(NUM_CH - 1);
      beat_r  <= '0;
    end else begin
      state_r <= state_nxt;
      grant_r <= grant_nxt;
      last_r  <= last_nxt;
      beat_r  <= beat_nxt;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter with a per-channel source model and
// an in-order scoreboard on the output side.
module tb_stream_rr_arbiter;

  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 4;
  localparam int unsigned BL  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]  in_valid;
  logic [NCH-1:0]  in_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int ptr  [NCH];
  int cnt  [NCH];
  int recv [NCH];
  logic en [NCH];

  logic            cur_xfer, cur_ovalid, cur_busy;
  logic [1:0]      cur_ch;
  logic [DW-1:0]   cur_data;
  logic [NCH-1:0]  cur_ready;
  logic [NCH-1:0]  xv;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] word(input int c, input int k);
    return DW'((c * 16) + (k % 16));
  endfunction

  function automatic bit all_done();
    for (int c = 0; c < NCH; c++) if (ptr[c] != cnt[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      in_valid[c]          = en[c] && (ptr[c] < cnt[c]);
      in_data[c*DW +: DW]  = word(c, ptr[c]);
    end
  endtask

  // One cycle: sample at negedge, run scoreboard, advance sources after posedge.
  task automatic step();
    @(negedge clk);
    cur_xfer   = out_valid && out_ready;
    cur_ovalid = out_valid;
    cur_busy   = busy;
    cur_ch     = out_ch;
    cur_data   = out_data;
    cur_ready  = in_ready;
    xv         = in_valid & in_ready;
    chk("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
    chk("xfer_coincide", 32'(|xv), 32'(cur_xfer));
    if (cur_xfer) begin
      chk("sb_ready", 32'(in_ready[out_ch]), 32'd1);
      chk("sb_data", 32'(out_data), 32'(word(int'(out_ch), recv[out_ch])));
      recv[out_ch]++;
    end
    @(posedge clk);
    for (int c = 0; c < NCH; c++) if (xv[c]) ptr[c]++;
    #1;
    drive();
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      ptr[c] = 0; cnt[c] = 0; recv[c] = 0; en[c] = 1'b0;
    end
    drive();

    // Reset state
    step();
    step();
    chk("rst_ovalid", 32'(cur_ovalid), 32'd0);
    chk("rst_ready", 32'(cur_ready), 32'd0);
    chk("rst_busy", 32'(cur_busy), 32'd0);
    chk("rst_ch", 32'(cur_ch), 32'd0);
    chk("rst_last", 32'(dut.last_r), 32'd3);
    chk("rst_beat", 32'(dut.beat_r), 32'd0);
    rst = 1'b0;

    // Single requester: ch2 sends 6 words
    en[2] = 1'b1; cnt[2] = 6; drive();
    step();
    chk("t1_idle_busy", 32'(cur_busy), 32'd0);
    chk("t1_idle_ovalid", 32'(cur_ovalid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_xfer", 32'(cur_xfer), 32'd1);
      chk("t1_ch", 32'(cur_ch), 32'd2);
      chk("t1_data", 32'(cur_data), 32'h20 + 32'(k));
      chk("t1_busy", 32'(cur_busy), 32'd1);
    end
    step();
    chk("t1_bubble_busy", 32'(cur_busy), 32'd0);
    chk("t1_bubble_xfer", 32'(cur_xfer), 32'd0);
    for (int k = 4; k < 6; k++) begin
      step();
      chk("t1_xfer2", 32'(cur_xfer), 32'd1);
      chk("t1_ch2", 32'(cur_ch), 32'd2);
      chk("t1_data2", 32'(cur_data), 32'h20 + 32'(k));
    end
    step();
    chk("t1_drop_busy", 32'(cur_busy), 32'd1);
    chk("t1_drop_ovalid", 32'(cur_ovalid), 32'd0);
    step();
    chk("t1_end_busy", 32'(cur_busy), 32'd0);
    chk("t1_last", 32'(dut.last_r), 32'd2);
    en[2] = 1'b0; drive();

    // All-valid rotation after a fresh reset
    rst = 1'b1; drive();
    step();
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      en[c] = 1'b1; cnt[c] = ptr[c] + 100;
    end
    drive();
    for (int g = 0; g < 5; g++) begin
      step();
      chk("t2_gap_busy", 32'(cur_busy), 32'd0);
      chk("t2_gap_xfer", 32'(cur_xfer), 32'd0);
      for (int b = 0; b < 4; b++) begin
        step();
        chk("t2_xfer", 32'(cur_xfer), 32'd1);
        chk("t2_ch", 32'(cur_ch), 32'(g % 4));
      end
    end
    for (int c = 0; c < NCH; c++) en[c] = 1'b0;
    drive();
    step();
    chk("t2_end_busy", 32'(cur_busy), 32'd0);
    chk("t2_last", 32'(dut.last_r), 32'd0);

    // Backpressure on a ch1 burst (ch1 already sent 4 words)
    en[1] = 1'b1; cnt[1] = ptr[1] + 4; drive();
    step();
    chk("t3_idle_busy", 32'(cur_busy), 32'd0);
    step();
    chk("t3_d0", 32'(cur_data), 32'h14);
    step();
    chk("t3_d1", 32'(cur_data), 32'h15);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("t3_hold_ovalid", 32'(cur_ovalid), 32'd1);
      chk("t3_hold_ch", 32'(cur_ch), 32'd1);
      chk("t3_hold_data", 32'(cur_data), 32'h16);
      chk("t3_hold_ready", 32'(cur_ready), 32'd0);
      chk("t3_hold_beat", 32'(dut.beat_r), 32'd2);
    end
    out_ready = 1'b1;
    step();
    chk("t3_d2", 32'(cur_data), 32'h16);
    chk("t3_d2_xfer", 32'(cur_xfer), 32'd1);
    step();
    chk("t3_d3", 32'(cur_data), 32'h17);
    step();
    chk("t3_end_busy", 32'(cur_busy), 32'd0);
    chk("t3_last", 32'(dut.last_r), 32'd1);
    en[1] = 1'b0; drive();

    // Early drop: ch3 offers only 2 words
    en[3] = 1'b1; cnt[3] = ptr[3] + 2; drive();
    step();
    step();
    chk("t4_d0", 32'(cur_data), 32'h34);
    chk("t4_ch", 32'(cur_ch), 32'd3);
    step();
    chk("t4_d1", 32'(cur_data), 32'h35);
    step();
    chk("t4_drop_busy", 32'(cur_busy), 32'd1);
    chk("t4_drop_ovalid", 32'(cur_ovalid), 32'd0);
    step();
    chk("t4_idle_busy", 32'(cur_busy), 32'd0);
    chk("t4_last", 32'(dut.last_r), 32'd3);
    en[0] = 1'b1; cnt[0] = ptr[0] + 1; cnt[3] = ptr[3] + 1; drive();
    step();
    step();
    chk("t4_pri_xfer", 32'(cur_xfer), 32'd1);
    chk("t4_pri_ch", 32'(cur_ch), 32'd0);
    chk("t4_pri_data", 32'(cur_data), 32'h08);
    step();
    step();
    step();
    chk("t4_next_ch", 32'(cur_ch), 32'd3);
    chk("t4_next_data", 32'(cur_data), 32'h36);
    step();
    step();
    en[0] = 1'b0; en[3] = 1'b0; drive();

    // Clear mid-burst on ch1, then all channels request together
    en[1] = 1'b1; cnt[1] = ptr[1] + 4; drive();
    step();
    step();
    chk("t5_d0", 32'(cur_data), 32'h18);
    step();
    chk("t5_d1", 32'(cur_data), 32'h19);
    clear = 1'b1;
    step();
    chk("t5_clr_ovalid", 32'(cur_ovalid), 32'd0);
    chk("t5_clr_ready", 32'(cur_ready), 32'd0);
    chk("t5_clr_busy", 32'(cur_busy), 32'd0);
    chk("t5_clr_xfer", 32'(cur_xfer), 32'd0);
    clear = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      en[c] = 1'b1;
      if (c != 1) cnt[c] = ptr[c] + 1;
    end
    drive();
    step();
    chk("t5_idle_busy", 32'(cur_busy), 32'd0);
    chk("t5_last", 32'(dut.last_r), 32'd3);
    chk("t5_beat", 32'(dut.beat_r), 32'd0);
    step();
    chk("t5_pri_xfer", 32'(cur_xfer), 32'd1);
    chk("t5_pri_ch", 32'(cur_ch), 32'd0);
    chk("t5_pri_data", 32'(cur_data), 32'h09);

    // Drain remaining words with a bounded cycle budget
    begin
      int n;
      n = 0;
      while (!all_done() && n < 80) begin
        step();
        n++;
      end
    end
    chk("drain_done", 32'(all_done()), 32'd1);
    for (int c = 0; c < NCH; c++) chk("sb_count", 32'(recv[c]), 32'(cnt[c]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
